// File: rtl/apb_pkg.sv
// Shared definitions for the APB timeout slice.
//   apb_state_e      : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   TIMEOUT_DISABLED : TIMEOUT_CYCLES value that turns the abort logic off
//   cnt_width()      : wait-counter width for a given timeout, never below 1
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned TIMEOUT_DISABLED = 0;

  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase wait counter and abort detection.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : zero the counter (transfer being accepted)
//   enable         : transfer is in its ACCESS phase
//   master_pready  : downstream ready; a ready cycle is never counted
//   expire         : this ACCESS cycle is the last one allowed (combinational)
module apb_watchdog
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic master_pready,
  output logic expire
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT =
    CW'((TIMEOUT_CYCLES == TIMEOUT_DISABLED) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !master_pready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Ready on the boundary cycle wins, so pready masks the abort.
  assign expire = (TIMEOUT_CYCLES != TIMEOUT_DISABLED) && enable &&
                  !master_pready && (cnt_q == LAST_CNT);

endmodule

// File: rtl/apb_timeout_slice.sv
// APB register slice with downstream access timeout.
// Captures one upstream APB transfer in IDLE, replays it downstream
// (SETUP then ACCESS), and answers upstream with a single-cycle ready in
// RESP. A downstream slave that stalls for TIMEOUT_CYCLES ACCESS cycles is
// abandoned with pslverr=1, prdata=0 and a one-cycle timeout_pulse.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   slave_*  (in)       : upstream request (paddr, pprot, psel, penable,
//                         pwrite, pwdata, pstrb)
//   slave_*  (out)      : upstream response (pready, prdata, pslverr)
//   master_* (out)      : downstream request, all registered
//   master_* (in)       : downstream response (pready, prdata, pslverr)
//   timeout_pulse       : high for the RESP cycle of an aborted transfer
module apb_timeout_slice
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   slave_paddr,
  input  logic                    slave_pprot,
  input  logic                    slave_psel,
  input  logic                    slave_penable,
  input  logic                    slave_pwrite,
  input  logic [DATA_WIDTH-1:0]   slave_pwdata,
  input  logic [DATA_WIDTH/8-1:0] slave_pstrb,
  output logic                    slave_pready,
  output logic [DATA_WIDTH-1:0]   slave_prdata,
  output logic                    slave_pslverr,
  output logic [ADDR_WIDTH-1:0]   master_paddr,
  output logic                    master_pprot,
  output logic                    master_psel,
  output logic                    master_penable,
  output logic                    master_pwrite,
  output logic [DATA_WIDTH-1:0]   master_pwdata,
  output logic [DATA_WIDTH/8-1:0] master_pstrb,
  input  logic                    master_pready,
  input  logic [DATA_WIDTH-1:0]   master_prdata,
  input  logic                    master_pslverr,
  output logic                    timeout_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  apb_state_e state_q, state_d;

  // Capture registers double as the downstream address/data outputs, so
  // they hold their value outside SETUP/ACCESS.
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pprot_q, pprot_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;

  // Control and response outputs are registered from next-state values.
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  spready_q, spready_d;
  logic [DATA_WIDTH-1:0] sprdata_q, sprdata_d;
  logic                  spslverr_q, spslverr_d;
  logic                  pulse_q, pulse_d;

  logic accept;
  logic in_access;
  logic expire;

  assign accept    = (state_q == ST_IDLE) && slave_psel && !slave_penable;
  assign in_access = (state_q == ST_ACCESS);

  apb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk           (clk),
    .reset         (reset),
    .clear         (accept),
    .enable        (in_access),
    .master_pready (master_pready),
    .expire        (expire)
  );

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pprot_d    = pprot_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    spready_d  = 1'b0;
    sprdata_d  = '0;
    spslverr_d = 1'b0;
    pulse_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          paddr_d  = slave_paddr;
          pprot_d  = slave_pprot;
          pwrite_d = slave_pwrite;
          pwdata_d = slave_pwdata;
          pstrb_d  = slave_pstrb;
          psel_d   = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (master_pready) begin
          state_d    = ST_RESP;
          spready_d  = 1'b1;
          sprdata_d  = master_prdata;
          spslverr_d = master_pslverr;
        end else if (expire) begin
          state_d    = ST_RESP;
          spready_d  = 1'b1;
          spslverr_d = 1'b1;
          pulse_d    = 1'b1;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      paddr_q    <= '0;
      pprot_q    <= 1'b0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      spready_q  <= 1'b0;
      sprdata_q  <= '0;
      spslverr_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pprot_q    <= pprot_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      spready_q  <= spready_d;
      sprdata_q  <= sprdata_d;
      spslverr_q <= spslverr_d;
      pulse_q    <= pulse_d;
    end
  end

  assign master_paddr   = paddr_q;
  assign master_pprot   = pprot_q;
  assign master_pwrite  = pwrite_q;
  assign master_pwdata  = pwdata_q;
  assign master_pstrb   = pstrb_q;
  assign master_psel    = psel_q;
  assign master_penable = penable_q;
  assign slave_pready   = spready_q;
  assign slave_prdata   = sprdata_q;
  assign slave_pslverr  = spslverr_q;
  assign timeout_pulse  = pulse_q;

endmodule

// File: tb/tb_apb_timeout_slice.sv
module tb_apb_timeout_slice;

  logic        clk;
  logic        reset;
  logic [10:0] s_paddr;
  logic        s_pprot, s_psel, s_penable, s_pwrite;
  logic [31:0] s_pwdata;
  logic [3:0]  s_pstrb;
  logic        m_pready, m_pslverr;
  logic [31:0] m_prdata;

  // Outputs of the TIMEOUT_CYCLES=4 instance (a_) and the disabled one (b_).
  logic        a_spready, a_spslverr, a_pprot, a_psel, a_penable, a_pwrite, a_pulse;
  logic [31:0] a_sprdata, a_pwdata;
  logic [10:0] a_paddr;
  logic [3:0]  a_pstrb;
  logic        b_spready, b_spslverr, b_pprot, b_psel, b_penable, b_pwrite, b_pulse;
  logic [31:0] b_sprdata, b_pwdata;
  logic [10:0] b_paddr;
  logic [3:0]  b_pstrb;

  // Observed instance: 0 -> timeout 4, 1 -> timeout disabled.
  logic        sel_nt;
  logic        o_spready, o_spslverr, o_pprot, o_psel, o_penable, o_pwrite, o_pulse;
  logic [31:0] o_sprdata, o_pwdata;
  logic [10:0] o_paddr;
  logic [3:0]  o_pstrb;

  assign o_spready  = sel_nt ? b_spready  : a_spready;
  assign o_spslverr = sel_nt ? b_spslverr : a_spslverr;
  assign o_sprdata  = sel_nt ? b_sprdata  : a_sprdata;
  assign o_pprot    = sel_nt ? b_pprot    : a_pprot;
  assign o_psel     = sel_nt ? b_psel     : a_psel;
  assign o_penable  = sel_nt ? b_penable  : a_penable;
  assign o_pwrite   = sel_nt ? b_pwrite   : a_pwrite;
  assign o_pwdata   = sel_nt ? b_pwdata   : a_pwdata;
  assign o_paddr    = sel_nt ? b_paddr    : a_paddr;
  assign o_pstrb    = sel_nt ? b_pstrb    : a_pstrb;
  assign o_pulse    = sel_nt ? b_pulse    : a_pulse;

  apb_timeout_slice #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .slave_paddr(s_paddr), .slave_pprot(s_pprot), .slave_psel(s_psel),
    .slave_penable(s_penable), .slave_pwrite(s_pwrite), .slave_pwdata(s_pwdata),
    .slave_pstrb(s_pstrb), .slave_pready(a_spready), .slave_prdata(a_sprdata),
    .slave_pslverr(a_spslverr), .master_paddr(a_paddr), .master_pprot(a_pprot),
    .master_psel(a_psel), .master_penable(a_penable), .master_pwrite(a_pwrite),
    .master_pwdata(a_pwdata), .master_pstrb(a_pstrb), .master_pready(m_pready),
    .master_prdata(m_prdata), .master_pslverr(m_pslverr), .timeout_pulse(a_pulse)
  );

  apb_timeout_slice #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .reset(reset),
    .slave_paddr(s_paddr), .slave_pprot(s_pprot), .slave_psel(s_psel),
    .slave_penable(s_penable), .slave_pwrite(s_pwrite), .slave_pwdata(s_pwdata),
    .slave_pstrb(s_pstrb), .slave_pready(b_spready), .slave_prdata(b_sprdata),
    .slave_pslverr(b_spslverr), .master_paddr(b_paddr), .master_pprot(b_pprot),
    .master_psel(b_psel), .master_penable(b_penable), .master_pwrite(b_pwrite),
    .master_pwdata(b_pwdata), .master_pstrb(b_pstrb), .master_pready(m_pready),
    .master_prdata(m_prdata), .master_pslverr(m_pslverr), .timeout_pulse(b_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        prot;
    int unsigned waits;      // ACCESS cycles with pready=0 before ready
    logic [31:0] rdata;
    logic        err;
    int unsigned exp_lat;    // cycles from setup sample to slave_pready
    int unsigned exp_acc;    // downstream ACCESS cycles
    logic [31:0] exp_prdata;
    logic        exp_err;
    logic        exp_pulse;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic wr, input logic [10:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic prot, input int unsigned waits,
                               input logic [31:0] rdata, input logic err,
                               input int unsigned lat, input int unsigned acc,
                               input logic [31:0] eprd, input logic eerr,
                               input logic epulse);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.waits = waits; v.rdata = rdata; v.err = err;
    v.exp_lat = lat; v.exp_acc = acc; v.exp_prdata = eprd;
    v.exp_err = eerr; v.exp_pulse = epulse;
    return v;
  endfunction

  // Reference: a transfer whose slave stalls for at least t cycles is
  // abandoned after exactly t ACCESS cycles; otherwise it takes waits+1.
  // Upstream sees ready two cycles after the last ACCESS cycle begins+1.
  function automatic vec_t model(input vec_t v, input int unsigned t);
    vec_t r;
    r = v;
    if (t != 0 && v.waits >= t) begin
      r.exp_acc = t; r.exp_prdata = '0; r.exp_err = 1'b1; r.exp_pulse = 1'b1;
    end else begin
      r.exp_acc = v.waits + 1; r.exp_prdata = v.rdata; r.exp_err = v.err;
      r.exp_pulse = 1'b0;
    end
    r.exp_lat = r.exp_acc + 2;
    return r;
  endfunction

  // Called at a negedge with the observed instance in IDLE. Returns at the
  // negedge of the cycle after RESP, where the next setup may be driven.
  task automatic xfer(input vec_t v, input bit scr);
    int unsigned cyc, acc, budget;
    bit got, quiet_bad, hold_bad;
    logic [31:0] r_prd;
    logic r_err, r_pulse;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = v.addr; s_pprot = v.prot;
    s_pwrite = v.wr; s_pwdata = v.wdata; s_pstrb = v.strb;
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("setup_psel", 64'(o_psel), 64'd1);
    chk("setup_penable", 64'(o_penable), 64'd0);
    chk("setup_fields", 64'({o_paddr, o_pprot, o_pwrite, o_pwdata, o_pstrb}),
        64'({v.addr, v.prot, v.wr, v.wdata, v.strb}));
    s_penable = 1'b1;
    if (scr) begin
      // Upstream misbehaves after capture; none of this may reach downstream.
      s_psel = 1'($urandom); s_penable = 1'($urandom);
      s_paddr = ~v.addr; s_pwdata = ~v.wdata; s_pwrite = ~v.wr;
      s_pstrb = ~v.strb; s_pprot = ~v.prot;
    end
    cyc = 1; acc = 0; got = 0; quiet_bad = 0; hold_bad = 0;
    budget = v.waits + 16;
    r_prd = '0; r_err = 1'b0; r_pulse = 1'b0;
    while (!got && cyc < budget) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (o_spready) begin
        got = 1; r_prd = o_sprdata; r_err = o_spslverr; r_pulse = o_pulse;
        m_pready = 1'b0;
      end else begin
        if (o_sprdata !== 32'd0 || o_spslverr !== 1'b0 || o_pulse !== 1'b0) quiet_bad = 1;
        if (o_psel && o_penable) begin
          if ({o_paddr, o_pprot, o_pwrite, o_pwdata, o_pstrb} !==
              {v.addr, v.prot, v.wr, v.wdata, v.strb}) hold_bad = 1;
          m_pready  = (acc == v.waits);
          m_prdata  = (acc == v.waits) ? v.rdata : $urandom;
          m_pslverr = (acc == v.waits) ? v.err : 1'($urandom);
          acc++;
        end else begin
          m_pready = 1'b0;
        end
      end
    end
    chk("resp_seen", 64'(got), 64'd1);
    if (got) begin
      chk("latency", 64'(cyc), 64'(v.exp_lat));
      chk("access_cycles", 64'(acc), 64'(v.exp_acc));
      chk("prdata", 64'(r_prd), 64'(v.exp_prdata));
      chk("pslverr", 64'(r_err), 64'(v.exp_err));
      chk("timeout_pulse", 64'(r_pulse), 64'(v.exp_pulse));
    end
    chk("quiet_before_resp", 64'(quiet_bad), 64'd0);
    chk("hold_fields", 64'(hold_bad), 64'd0);
    s_psel = 1'b0; s_penable = 1'b0; m_pready = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("after_resp_idle",
        64'({o_spready, o_pulse, o_sprdata, o_spslverr, o_psel, o_penable}), 64'd0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    n_chk = 0; n_fail = 0; sel_nt = 1'b0;
    reset = 1'b1;
    s_paddr = '0; s_pprot = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    s_pwrite = 1'b0; s_pwdata = '0; s_pstrb = '0;
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;

    //              wr  addr     wdata         strb  prot waits rdata         err lat acc exp_prdata   err pulse
    tbl[0] = mkv(1, 11'h024, 32'hDEADBEEF, 4'hF, 0,  0, 32'h00000000, 0, 3, 1, 32'h00000000, 0, 0);
    tbl[1] = mkv(0, 11'h100, 32'h00000000, 4'h0, 0,  3, 32'h12345678, 0, 6, 4, 32'h12345678, 0, 0);
    tbl[2] = mkv(0, 11'h200, 32'h00000000, 4'h0, 0, 10, 32'h11111111, 0, 6, 4, 32'h00000000, 1, 1);
    tbl[3] = mkv(0, 11'h204, 32'h00000000, 4'h0, 1,  3, 32'hCAFEF00D, 0, 6, 4, 32'hCAFEF00D, 0, 0);
    tbl[4] = mkv(1, 11'h7FC, 32'hA5A5A5A5, 4'h3, 0,  1, 32'h55AA55AA, 1, 4, 2, 32'h55AA55AA, 1, 0);
    tbl[5] = mkv(0, 11'h3FF, 32'h00000000, 4'h0, 1,  2, 32'hFFFFFFFF, 0, 5, 3, 32'hFFFFFFFF, 0, 0);
    tbl[6] = mkv(1, 11'h000, 32'h00000001, 4'h1, 0,  4, 32'h22222222, 0, 6, 4, 32'h00000000, 1, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_master_t4", 64'({a_psel, a_penable, a_paddr, a_pprot, a_pwrite, a_pwdata, a_pstrb}), 64'd0);
    chk("reset_slave_t4", 64'({a_spready, a_sprdata, a_spslverr, a_pulse}), 64'd0);
    chk("reset_master_t0", 64'({b_psel, b_penable, b_paddr, b_pprot, b_pwrite, b_pwdata, b_pstrb}), 64'd0);
    chk("reset_slave_t0", 64'({b_spready, b_sprdata, b_spslverr, b_pulse}), 64'd0);
    reset = 1'b0;

    // Table vectors, back to back, first one on the first cycle out of reset.
    for (int i = 0; i < 7; i++) xfer(tbl[i], bit'(i % 2));

    // Reset during ACCESS drops the downstream transfer with no response.
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 11'h0AA; s_pwrite = 1'b0;
    s_pwdata = '0; s_pstrb = '0; s_pprot = 1'b0; m_pready = 1'b0;
    @(posedge clk); @(negedge clk);
    s_penable = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_access", 64'({o_psel, o_penable}), 64'd3);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_drop", 64'({o_psel, o_penable, o_spready, o_pulse}), 64'd0);
    reset = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    xfer(mkv(1, 11'h155, 32'h0F0F0F0F, 4'hC, 1, 0, 32'h0, 0, 3, 1, 32'h0, 0, 0), 0);

    // Randomized transfers against the reference model (timeout 4).
    for (int i = 0; i < 40; i++) begin
      rv.wr = 1'($urandom); rv.addr = 11'($urandom); rv.wdata = $urandom;
      rv.strb = 4'($urandom); rv.prot = 1'($urandom);
      rv.waits = $urandom_range(0, 6); rv.rdata = $urandom; rv.err = 1'($urandom);
      rv = model(rv, 4);
      xfer(rv, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Timeout disabled: a 1000-cycle stall still completes normally.
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; sel_nt = 1'b1;
    xfer(mkv(0, 11'h010, 32'h0, 4'h0, 0, 1000, 32'h13579BDF, 0, 1003, 1001,
             32'h13579BDF, 0, 0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, time %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
